mdu_sequencer: RTL

//  Parametrised multi-cycle multiply/divide sequencer with HI/LO registers and D-stage hazard output.

---
 rtl/mdu_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer with HI/LO registers, MADD/MSUB accumulate,
// MTHI/MTLO writes, exception flush and a D-stage stall output.
module mdu_sequencer #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  input  logic             md_in_d,
  output logic             busy,
  output logic             stall_d,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES - 1);

  state_e             state_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;

  logic               is_signed, is_div, a_neg, b_neg;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, hilo_cur, mul_res;
  logic [WIDTH-1:0]   a_mag, b_mag, div_b, q_mag, r_mag, quot, rem;

  // Result datapath from latched operands; {HI,LO} read here is the value at commit.
  always_comb begin
    is_signed = ~op_q[0];
    is_div    = (op_q[2:1] == 2'b01);
    a_ext     = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext     = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod      = a_ext * b_ext;
    hilo_cur  = {hi_q, lo_q};
    if (!op_q[2]) begin
      mul_res = prod;
    end else if (op_q[1]) begin
      mul_res = hilo_cur - prod;
    end else begin
      mul_res = hilo_cur + prod;
    end
    // Divide on magnitudes so most-negative / -1 wraps cleanly instead of overflowing.
    a_neg = is_signed & a_q[WIDTH-1];
    b_neg = is_signed & b_q[WIDTH-1];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    div_b = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag = a_mag / div_b;
    r_mag = a_mag % div_b;
    quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

  // Sequencer FSM, operand latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= (op[2:1] == 2'b01) ? DIV_N : MULT_N;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else if (hilo_we && !flush) begin
            if (hilo_sel) begin
              hi_q <= wdata;
            end else begin
              lo_q <= wdata;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!is_div) begin
              {hi_q, lo_q} <= mul_res;
            end else if (b_q != '0) begin
              hi_q <= rem;
              lo_q <= quot;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign stall_d = md_in_d & (busy_q | start);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rdata   = hilo_sel ? hi_q : lo_q;

endmodule
